// File: rtl/dcache_resp_model.sv
// Purpose : dcache stand-in that services the packed EX-stage request word from a word-organised store.
// Latency : response valid LATENCY edges after the accept edge (accept edge counts as the first).
// Backpr. : one request in flight; req_ready low until the response is taken with resp_ready.
//
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   req_bus[105:0]        {valid, op, addr[31:0], uncached, awstrb[3:0], wdata[31:0],
//                          cacop_en, cacop_code[1:0], cacop_addr[31:0]}
//   req_ready             high in IDLE; accept = req_ready & req_bus valid
//   resp_valid/ready      response handshake; rdata/err held stable while resp_valid & !resp_ready
//   resp_rdata, resp_err  read data (0 for writes/cacops), error flag
//   busy                  high whenever not IDLE
// Optional feature: define DCACHE_RESP_MODEL_RANGE_ERR_EN to flag word addresses >= DEPTH
// (write suppressed, rdata 0, resp_err 1). Undefined: index wraps and resp_err stays 0.

`ifndef EXM_DCACHE_WD
`define EXM_DCACHE_WD 106
`endif

module dcache_resp_model #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`EXM_DCACHE_WD-1:0] req_bus,
  output logic                      req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int IDXW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  // Request fields straight off the bus
  logic        bus_vld;
  logic        bus_op;
  logic [31:0] bus_addr;
  logic [3:0]  bus_strb;
  logic [31:0] bus_wdata;
  logic        bus_cacop;

  assign bus_vld   = req_bus[105];
  assign bus_op    = req_bus[104];
  assign bus_addr  = req_bus[103:72];
  assign bus_strb  = req_bus[70:67];
  assign bus_wdata = req_bus[66:35];
  assign bus_cacop = req_bus[34];

  // Fields latched at the accept edge
  logic        op_q;
  logic [31:0] addr_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic        cacop_q;

  logic [31:0] mem [DEPTH];

  logic accept;
  assign accept = (state_q == ST_IDLE) && bus_vld;

  // With LATENCY==1 the commit coincides with the accept edge, so the commit
  // must take its fields from the bus rather than from the latched copy.
  logic        cmt_op;
  logic [31:0] cmt_addr;
  logic [3:0]  cmt_strb;
  logic [31:0] cmt_wdata;
  logic        cmt_cacop;
  logic        from_bus;

  assign from_bus  = (state_q == ST_IDLE);
  assign cmt_op    = from_bus ? bus_op    : op_q;
  assign cmt_addr  = from_bus ? bus_addr  : addr_q;
  assign cmt_strb  = from_bus ? bus_strb  : strb_q;
  assign cmt_wdata = from_bus ? bus_wdata : wdata_q;
  assign cmt_cacop = from_bus ? bus_cacop : cacop_q;

  logic [IDXW-1:0] idx;
  logic            oor;
  logic [31:0]     rdata_d;

  assign idx = cmt_addr[IDXW+1:2];

`ifdef DCACHE_RESP_MODEL_RANGE_ERR_EN
  assign oor = (cmt_addr[31:2] >> IDXW) != 30'd0;
`else
  assign oor = 1'b0;
`endif

  // Reads never coincide with a write, so the stored word is already post-commit.
  assign rdata_d = (cmt_op || cmt_cacop || oor) ? 32'h0 : mem[idx];

  // Uncached, cacop code/address and the unindexed address bits do not affect behaviour.
  logic unused_ok;
  assign unused_ok = ^{req_bus[71], req_bus[33:0], cmt_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= bus_op;
      addr_q  <= bus_addr;
      strb_q  <= bus_strb;
      wdata_q <= bus_wdata;
      cacop_q <= bus_cacop;
    end
  end

  // Store is not reset; a reset held across the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (commit && !reset && cmt_op && !cmt_cacop && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (cmt_strb[i]) mem[idx][8*i +: 8] <= cmt_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_rdata <= rdata_d;
      resp_err   <= oor;
    end else if (state_q == ST_RESP && resp_ready) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dcache_resp_model.sv
module tb_dcache_resp_model;

`ifdef DCACHE_RESP_MODEL_RANGE_ERR_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Two instances: LATENCY=2 (sel=0) and LATENCY=3 (sel=1); the task steers stimulus by sel.
  int sel = 0;
  logic [105:0] req_drv = '0;
  logic         rr_drv  = 1'b1;

  logic [105:0] a_req, b_req;
  logic         a_rr, b_rr;
  logic         a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic         b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0]  a_rdata, b_rdata;

  assign a_req = (sel == 0) ? req_drv : '0;
  assign b_req = (sel == 1) ? req_drv : '0;
  assign a_rr  = (sel == 0) ? rr_drv  : 1'b1;
  assign b_rr  = (sel == 1) ? rr_drv  : 1'b1;

  logic        m_req_ready, m_resp_valid, m_err, m_busy;
  logic [31:0] m_rdata;
  assign m_req_ready  = (sel == 1) ? b_req_ready  : a_req_ready;
  assign m_resp_valid = (sel == 1) ? b_resp_valid : a_resp_valid;
  assign m_err        = (sel == 1) ? b_resp_err   : a_resp_err;
  assign m_busy       = (sel == 1) ? b_busy       : a_busy;
  assign m_rdata      = (sel == 1) ? b_rdata      : a_rdata;

  dcache_resp_model #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_bus(a_req), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_ready(a_rr), .resp_rdata(a_rdata),
    .resp_err(a_resp_err), .busy(a_busy));

  dcache_resp_model #(.DEPTH(1024), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_bus(b_req), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_ready(b_rr), .resp_rdata(b_rdata),
    .resp_err(b_resp_err), .busy(b_busy));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [105:0] pack(input logic op, input logic [31:0] addr,
                                        input logic [3:0] strb, input logic [31:0] wdata,
                                        input logic cacop);
    return {1'b1, op, addr, 1'b0, strb, wdata, cacop, 2'b00, 32'h0};
  endfunction

  // One full transaction with resp_ready held high; checks latency and one-cycle response.
  task automatic run_req(input int sel_i, input logic op, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata, input logic cacop,
                         output logic [31:0] rd, output logic er);
    int edges;
    sel = sel_i;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, m_req_ready}, 32'd1);
    req_drv = pack(op, addr, strb, wdata, cacop);
    rr_drv  = 1'b1;
    @(posedge clk); #1;
    req_drv = '0;
    edges = 1;
    while (!m_resp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency_edges", 32'(edges), (sel_i == 1) ? 32'd3 : 32'd2);
    rd = m_rdata;
    er = m_err;
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, m_resp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        cacop;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          guard;

    vecs[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   4'h5, 32'h11223344, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,   4'h0, 32'h0,        1'b0, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{1'b1, 32'h10,   4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'hDE22BE44, 1'b0};
    vecs[7]  = '{1'b1, 32'h4,    4'hF, 32'h01020304, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h4,    4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h4,    4'h0, 32'h0,        1'b0, 32'h01020304, 1'b0};
    vecs[10] = '{1'b1, 32'hFFC,  4'hF, 32'h0BADC0DE, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'hFFC,  4'h0, 32'h0,        1'b0, 32'h0BADC0DE, 1'b0};
    vecs[12] = '{1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h1000, 4'h0, 32'h0,        1'b0,
                 RANGE_EN ? 32'h0 : 32'hCAFEF00D, RANGE_EN};
    vecs[14] = '{1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0, 32'h0, RANGE_EN};
    vecs[15] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0,
                 RANGE_EN ? 32'hCAFEF00D : 32'h12345678, 1'b0};

    // Reset state
    #12;
    chk("rst_req_ready",  {31'd0, a_req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_rdata",      a_rdata,               32'd0);
    chk("rst_err",        {31'd0, a_resp_err},   32'd0);
    chk("rst_busy",       {31'd0, a_busy},       32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_req(0, vecs[i].op, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].cacop, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Backpressure: hold resp_ready low for 5 cycles while a second request waits on the bus
    sel = 0;
    @(negedge clk);
    req_drv = pack(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    rr_drv  = 1'b0;
    @(posedge clk); #1;
    req_drv = pack(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b0);
    guard = 0;
    while (!a_resp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("hold_reached_resp", {31'd0, a_resp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid",     {31'd0, a_resp_valid}, 32'd1);
      chk("hold_rdata",     a_rdata,               32'hDE22BE44);
      chk("hold_req_ready", {31'd0, a_req_ready},  32'd0);
    end
    @(negedge clk);
    rr_drv  = 1'b1;
    req_drv = '0;
    @(posedge clk); #1;
    chk("release_valid",     {31'd0, a_resp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, a_req_ready},  32'd1);
    run_req(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er);
    chk("held_req_not_taken", rd, 32'hDE22BE44);

    // LATENCY=3 instance: reset before the commit edge cancels the write
    run_req(1, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, 1'b0, rd, er);
    chk("l3_write_rdata", rd, 32'h0);
    sel = 1;
    @(negedge clk);
    req_drv = pack(1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, 1'b0);
    @(posedge clk); #1;
    req_drv = '0;
    chk("l3_busy_after_accept", {31'd0, b_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'd0, b_resp_valid}, 32'd0);
    chk("midrst_req_ready",  {31'd0, b_req_ready},  32'd1);
    chk("midrst_busy",       {31'd0, m_busy},       32'd0);
    chk("midrst_rdata",      b_rdata,               32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_req(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd, er);
    chk("midrst_no_commit", rd, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
